// File: rtl/gesture_arm_sequencer_if.sv
// Gesture input and joint-command handshake bundle for the arm sequencer.
// master: the sequencer side; slave: the recognizer/servo environment side.
interface gesture_arm_sequencer_if #(
    parameter int unsigned ANGLE_W = 8
);
    logic               gesture_valid;
    logic [3:0]         finger_count;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_joint;
    logic [ANGLE_W-1:0] cmd_angle;

    modport master (
        input  gesture_valid, finger_count, cmd_ready,
        output cmd_valid, cmd_joint, cmd_angle
    );

    modport slave (
        output gesture_valid, finger_count, cmd_ready,
        input  cmd_valid, cmd_joint, cmd_angle
    );
endinterface

// File: rtl/gesture_arm_sequencer.sv
// Gesture arm sequencer: debounces per-frame finger counts, maps stable
// gestures to joint select / angle step / gripper / home actions, and issues
// one joint-angle command at a time over a valid/ready handshake.
module gesture_arm_sequencer #(
    parameter int unsigned STABLE_FRAMES = 3,
    parameter int unsigned ANGLE_W       = 8,
    parameter int unsigned STEP          = 4,
    parameter int unsigned ANGLE_MIN     = 0,
    parameter int unsigned ANGLE_MAX     = 180,
    parameter int unsigned HOME_ANGLE    = 90,
    parameter int unsigned IDLE_TIMEOUT  = 50000000,
    parameter int unsigned TO_W          = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    gesture_arm_sequencer_if.master  bus,
    output logic [1:0]               sel_joint,
    output logic                     gripper_closed,
    output logic                     busy,
    output logic                     drop_pulse
);

    localparam logic [3:0]         SF4    = 4'(STABLE_FRAMES);
    localparam logic [ANGLE_W:0]   STEP_X = (ANGLE_W+1)'(STEP);
    localparam logic [ANGLE_W:0]   MAX_X  = (ANGLE_W+1)'(ANGLE_MAX);
    localparam logic [ANGLE_W:0]   MIN_X  = (ANGLE_W+1)'(ANGLE_MIN);
    localparam logic [ANGLE_W-1:0] STEP_A = ANGLE_W'(STEP);
    localparam logic [ANGLE_W-1:0] MAX_A  = ANGLE_W'(ANGLE_MAX);
    localparam logic [ANGLE_W-1:0] MIN_A  = ANGLE_W'(ANGLE_MIN);
    localparam logic [ANGLE_W-1:0] HOME_A = ANGLE_W'(HOME_ANGLE);
    localparam logic [TO_W-1:0]    TO_LIM = TO_W'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOME} state_t;

    state_t             state, state_d;
    logic [3:0]         cand, run;
    logic [3:0]         fc_norm, run_inc, run_new;
    logic               same, fire, hand, step_type;
    logic               act_step, act_home, act_sel, act_grip;
    logic               timed_out, go_issue, go_home;
    logic [ANGLE_W-1:0] angle [4];
    logic [ANGLE_W-1:0] cur, ang_up, ang_dn, new_ang;
    logic [ANGLE_W:0]   inc_x;
    logic [1:0]         cmd_joint_q;
    logic [ANGLE_W-1:0] cmd_angle_q;
    logic [TO_W-1:0]    to_cnt;

    assign bus.cmd_joint = cmd_joint_q;
    assign bus.cmd_angle = cmd_angle_q;

    // Debounce decode, action decode, saturating angle arithmetic.
    always_comb begin
        fc_norm   = (bus.finger_count > 4'd5) ? 4'd0 : bus.finger_count;
        same      = (fc_norm == cand);
        run_inc   = (run == 4'hF) ? run : run + 4'd1;
        run_new   = same ? run_inc : 4'd1;
        // Saturated run sitting at the threshold must not re-fire.
        fire      = bus.gesture_valid && (run_new == SF4) && !(same && run == SF4);
        hand      = bus.gesture_valid && (fc_norm != 4'd0);
        step_type = (fc_norm == 4'd2) || (fc_norm == 4'd3);
        act_step  = fire && step_type;
        act_home  = fire && (fc_norm == 4'd5);
        act_sel   = fire && (fc_norm == 4'd1);
        act_grip  = fire && (fc_norm == 4'd4);
        timed_out = (to_cnt == TO_LIM);
        go_issue  = (state == S_IDLE) && act_step;
        go_home   = (state == S_IDLE) && (act_home || (timed_out && !hand));
        cur       = angle[sel_joint];
        inc_x     = {1'b0, cur} + STEP_X;
        ang_up    = (inc_x > MAX_X) ? MAX_A : inc_x[ANGLE_W-1:0];
        ang_dn    = ({1'b0, cur} < MIN_X + STEP_X) ? MIN_A : cur - STEP_A;
        new_ang   = (fc_norm == 4'd2) ? ang_up : ang_dn;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_d       = state;
        bus.cmd_valid = 1'b0;
        busy          = 1'b0;
        case (state)
            S_IDLE: begin
                if (go_issue)     state_d = S_ISSUE;
                else if (go_home) state_d = S_HOME;
            end
            S_ISSUE: begin
                bus.cmd_valid = 1'b1;
                busy          = 1'b1;
                if (bus.cmd_ready) state_d = S_IDLE;
            end
            S_HOME: begin
                bus.cmd_valid = 1'b1;
                busy          = 1'b1;
                if (bus.cmd_ready && cmd_joint_q == 2'd3) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Debounce state, joint angles, command registers, selection, gripper, timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand           <= '0;
            run            <= '0;
            sel_joint      <= '0;
            gripper_closed <= 1'b0;
            drop_pulse     <= 1'b0;
            cmd_joint_q    <= '0;
            cmd_angle_q    <= HOME_A;
            to_cnt         <= '0;
            for (int unsigned j = 0; j < 4; j++) angle[j] <= HOME_A;
        end else begin
            if (bus.gesture_valid) begin
                cand <= fc_norm;
                run  <= (fire && step_type) ? 4'd0 : run_new;
            end
            drop_pulse <= (act_step || act_home) && (state != S_IDLE);
            if (act_sel)  sel_joint      <= sel_joint + 2'd1;
            if (act_grip) gripper_closed <= ~gripper_closed;
            if (go_issue) begin
                angle[sel_joint] <= new_ang;
                cmd_joint_q      <= sel_joint;
                cmd_angle_q      <= new_ang;
            end else if (go_home) begin
                for (int unsigned j = 0; j < 4; j++) angle[j] <= HOME_A;
                cmd_joint_q <= '0;
                cmd_angle_q <= HOME_A;
            end else if (state == S_HOME && bus.cmd_ready && cmd_joint_q != 2'd3) begin
                cmd_joint_q <= cmd_joint_q + 2'd1;
            end
            if (hand || go_home)   to_cnt <= '0;
            else if (!timed_out)   to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_gesture_arm_sequencer.sv
// Directed self-checking bench for gesture_arm_sequencer.
module tb_gesture_arm_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] sel_joint;
    logic gripper_closed, busy, drop_pulse;

    int tests = 0;
    int fails = 0;
    int n_cmds = 0;
    int n_drops = 0;
    int rec_joint [256];
    int rec_angle [256];

    gesture_arm_sequencer_if #(.ANGLE_W(8)) bus ();

    gesture_arm_sequencer #(
        .STABLE_FRAMES(3), .ANGLE_W(8), .STEP(4), .ANGLE_MIN(0),
        .ANGLE_MAX(180), .HOME_ANGLE(90), .IDLE_TIMEOUT(100), .TO_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master),
        .sel_joint(sel_joint), .gripper_closed(gripper_closed),
        .busy(busy), .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    // Record accepted commands and drop pulses mid-cycle.
    always @(negedge clk) begin
        if (rst_n && bus.cmd_valid && bus.cmd_ready && n_cmds < 256) begin
            rec_joint[n_cmds] = int'(bus.cmd_joint);
            rec_angle[n_cmds] = int'(bus.cmd_angle);
            n_cmds++;
        end
        if (rst_n && drop_pulse) n_drops++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int v);
        bus.gesture_valid = 1'b1;
        bus.finger_count  = 4'(v);
        tick();
        bus.gesture_valid = 1'b0;
        bus.finger_count  = 4'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.gesture_valid = 1'b0;
        bus.finger_count  = 4'd0;
        bus.cmd_ready     = 1'b0;
        tick();
        tick();
        n_cmds  = 0;
        n_drops = 0;
        rst_n   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.gesture_valid = 1'b0;
        bus.finger_count  = 4'd0;
        bus.cmd_ready     = 1'b0;
        tick();
        tests++;
        if ({bus.cmd_valid, bus.cmd_joint, bus.cmd_angle} !== {1'b0, 2'd0, 8'd90}) begin
            fails++;
            $display("FAIL reset_cmd: got v=%0b j=%0d a=%0d, want v=0 j=0 a=90",
                     bus.cmd_valid, bus.cmd_joint, bus.cmd_angle);
        end
        tests++;
        if ({sel_joint, gripper_closed, busy, drop_pulse} !== 5'b0) begin
            fails++;
            $display("FAIL reset_status: got sel=%0d grip=%0b busy=%0b drop=%0b, want all 0",
                     sel_joint, gripper_closed, busy, drop_pulse);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.cmd_ready = 1'b1;
        pulse(2);
        pulse(2);
        tests++;
        if (bus.cmd_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_early: cmd_valid=%0b after 2 pulses, want 0", bus.cmd_valid);
        end
        pulse(2);
        tests++;
        if ({bus.cmd_valid, busy, bus.cmd_joint, bus.cmd_angle} !== {1'b1, 1'b1, 2'd0, 8'd94}) begin
            fails++;
            $display("FAIL single_cmd: got v=%0b busy=%0b j=%0d a=%0d, want v=1 busy=1 j=0 a=94",
                     bus.cmd_valid, busy, bus.cmd_joint, bus.cmd_angle);
        end
        tick();
        tests++;
        if ({bus.cmd_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL single_done: got v=%0b busy=%0b, want 0 0", bus.cmd_valid, busy);
        end
        tick();
        tick();
        tests++;
        if (n_cmds != 1) begin
            fails++;
            $display("FAIL single_count: got %0d commands, want 1", n_cmds);
        end
    endtask

    task automatic test_inc_sat();
        int exp_a;
        do_reset();
        bus.cmd_ready = 1'b1;
        for (int i = 0; i < 156; i++) pulse(2);
        tick();
        tick();
        tests++;
        if (n_cmds != 52) begin
            fails++;
            $display("FAIL inc_count: got %0d commands, want 52", n_cmds);
        end
        exp_a = 90;
        for (int k = 0; k < 52 && k < n_cmds; k++) begin
            exp_a = (exp_a + 4 > 180) ? 180 : exp_a + 4;
            tests++;
            if (rec_angle[k] != exp_a || rec_joint[k] != 0) begin
                fails++;
                $display("FAIL inc_angle[%0d]: got j=%0d a=%0d, want j=0 a=%0d",
                         k, rec_joint[k], rec_angle[k], exp_a);
            end
        end
        tests++;
        if (n_drops != 0) begin
            fails++;
            $display("FAIL inc_drops: got %0d drops, want 0", n_drops);
        end
    endtask

    task automatic test_dec_floor();
        int exp_a;
        do_reset();
        bus.cmd_ready = 1'b1;
        for (int i = 0; i < 72; i++) pulse(3);
        tick();
        tick();
        tests++;
        if (n_cmds != 24) begin
            fails++;
            $display("FAIL dec_count: got %0d commands, want 24", n_cmds);
        end
        exp_a = 90;
        for (int k = 0; k < 24 && k < n_cmds; k++) begin
            exp_a = (exp_a < 4) ? 0 : exp_a - 4;
            tests++;
            if (rec_angle[k] != exp_a) begin
                fails++;
                $display("FAIL dec_angle[%0d]: got %0d, want %0d", k, rec_angle[k], exp_a);
            end
        end
    endtask

    task automatic test_sel_grip();
        do_reset();
        bus.cmd_ready = 1'b1;
        pulse(1); pulse(1); pulse(1);
        tests++;
        if (sel_joint !== 2'd1) begin
            fails++;
            $display("FAIL sel_inc: got sel=%0d, want 1", sel_joint);
        end
        pulse(1);
        tests++;
        if (sel_joint !== 2'd1) begin
            fails++;
            $display("FAIL sel_hold: got sel=%0d after held 1, want 1", sel_joint);
        end
        pulse(4); pulse(4); pulse(4);
        tests++;
        if (gripper_closed !== 1'b1) begin
            fails++;
            $display("FAIL grip_toggle: got %0b, want 1", gripper_closed);
        end
        pulse(2); pulse(2); pulse(1); pulse(2);
        tick();
        tests++;
        if (n_cmds != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL broken_run: got %0d commands busy=%0b, want 0 0", n_cmds, busy);
        end
        pulse(0);
        pulse(2); pulse(2); pulse(2);
        tests++;
        if ({bus.cmd_valid, bus.cmd_joint, bus.cmd_angle} !== {1'b1, 2'd1, 8'd94}) begin
            fails++;
            $display("FAIL sel_target: got v=%0b j=%0d a=%0d, want v=1 j=1 a=94",
                     bus.cmd_valid, bus.cmd_joint, bus.cmd_angle);
        end
        tick();
    endtask

    task automatic test_home_stall();
        bit stable;
        do_reset();
        bus.cmd_ready = 1'b1;
        pulse(2); pulse(2); pulse(2);
        tick();
        bus.cmd_ready = 1'b0;
        pulse(5); pulse(5); pulse(5);
        tests++;
        if ({bus.cmd_valid, busy, bus.cmd_joint, bus.cmd_angle} !== {1'b1, 1'b1, 2'd0, 8'd90}) begin
            fails++;
            $display("FAIL home_first: got v=%0b busy=%0b j=%0d a=%0d, want 1 1 0 90",
                     bus.cmd_valid, busy, bus.cmd_joint, bus.cmd_angle);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ({bus.cmd_valid, bus.cmd_joint, bus.cmd_angle} !== {1'b1, 2'd0, 8'd90}) stable = 1'b0;
        end
        tests++;
        if (!stable) begin
            fails++;
            $display("FAIL home_stall: got v=%0b j=%0d a=%0d, want held 1 0 90",
                     bus.cmd_valid, bus.cmd_joint, bus.cmd_angle);
        end
        bus.cmd_ready = 1'b1;
        for (int j = 1; j < 4; j++) begin
            tick();
            tests++;
            if ({bus.cmd_valid, bus.cmd_joint, bus.cmd_angle} !== {1'b1, 2'(j), 8'd90}) begin
                fails++;
                $display("FAIL home_seq%0d: got v=%0b j=%0d a=%0d, want 1 %0d 90",
                         j, bus.cmd_valid, bus.cmd_joint, bus.cmd_angle, j);
            end
        end
        tick();
        tests++;
        if ({bus.cmd_valid, busy} !== 2'b00 || n_cmds != 5) begin
            fails++;
            $display("FAIL home_end: got v=%0b busy=%0b cmds=%0d, want 0 0 5",
                     bus.cmd_valid, busy, n_cmds);
        end
        for (int k = 1; k < 5 && k < n_cmds; k++) begin
            tests++;
            if (rec_joint[k] != k - 1 || rec_angle[k] != 90) begin
                fails++;
                $display("FAIL home_rec[%0d]: got j=%0d a=%0d, want j=%0d a=90",
                         k, rec_joint[k], rec_angle[k], k - 1);
            end
        end
        pulse(2); pulse(2); pulse(2);
        tests++;
        if (bus.cmd_angle !== 8'd94) begin
            fails++;
            $display("FAIL home_angles: got %0d after home then step, want 94", bus.cmd_angle);
        end
        tick();
    endtask

    task automatic test_drop();
        do_reset();
        bus.cmd_ready = 1'b0;
        pulse(2); pulse(2); pulse(2);
        pulse(2); pulse(2); pulse(2);
        tests++;
        if (drop_pulse !== 1'b1) begin
            fails++;
            $display("FAIL drop_assert: got %0b, want 1", drop_pulse);
        end
        tests++;
        if ({bus.cmd_valid, bus.cmd_joint, bus.cmd_angle} !== {1'b1, 2'd0, 8'd94}) begin
            fails++;
            $display("FAIL drop_cmd: got v=%0b j=%0d a=%0d, want 1 0 94",
                     bus.cmd_valid, bus.cmd_joint, bus.cmd_angle);
        end
        tick();
        tests++;
        if (drop_pulse !== 1'b0 || n_drops != 1) begin
            fails++;
            $display("FAIL drop_width: got drop=%0b count=%0d, want 0 1", drop_pulse, n_drops);
        end
        bus.cmd_ready = 1'b1;
        tick();
        pulse(2); pulse(2); pulse(2);
        tests++;
        if (bus.cmd_angle !== 8'd98) begin
            fails++;
            $display("FAIL drop_noupdate: got %0d, want 98", bus.cmd_angle);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        bus.cmd_ready = 1'b1;
        n = 0;
        while (n < 300 && bus.cmd_valid !== 1'b1) begin
            tick();
            n++;
        end
        tests++;
        if (n != 101) begin
            fails++;
            $display("FAIL timeout_start: home after %0d cycles, want 101", n);
        end
        tick(); tick(); tick(); tick();
        tests++;
        if (bus.cmd_valid !== 1'b0 || n_cmds != 4) begin
            fails++;
            $display("FAIL timeout_seq: got v=%0b cmds=%0d, want 0 4", bus.cmd_valid, n_cmds);
        end

        do_reset();
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            n++;
        end
        pulse(1);
        n++;
        while (n < 400 && bus.cmd_valid !== 1'b1) begin
            tick();
            n++;
        end
        tests++;
        if (n != 162) begin
            fails++;
            $display("FAIL timeout_delay: home after %0d cycles, want 162", n);
        end
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.cmd_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL reset_midhome: got v=%0b busy=%0b, want 0 0", bus.cmd_valid, busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (bus.cmd_valid !== 1'b0 || n_cmds != 0) begin
            fails++;
            $display("FAIL reset_nocomplete: got v=%0b cmds=%0d, want 0 0", bus.cmd_valid, n_cmds);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_inc_sat();
        test_dec_floor();
        test_sel_grip();
        test_home_stall();
        test_drop();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
